// File: rtl/fix_pkg.sv
// Shared FIX constants and the inbound checksum-check state encoding.
package fix_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  typedef enum logic [2:0] {
    IDLE,
    BODY,
    TAG1,
    TAG0,
    DIG,
    SKIP,
    REPORT
  } chk_state_t;

endpackage

// File: rtl/fix_ascii_digit.sv
// Combinational ASCII decimal digit decoder, shared with the outbound checksum formatter.
module fix_ascii_digit
  import fix_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_digit,
  output logic [3:0] value
);

  always_comb begin
    is_digit = (data >= ASCII_0) && (data <= ASCII_0 + 8'd9);
    value    = is_digit ? data[3:0] : 4'd0;
  end

endmodule

// File: rtl/fix_checksum_check.sv
// Inbound FIX checksum checker: mod-256 body sum, 10=NNN trailer parse and verdict.
module fix_checksum_check
  import fix_pkg::*;
#(
  parameter logic [7:0] SOH = fix_pkg::SOH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       sop_i,
  output logic       done_o,
  output logic       match_o,
  output logic       fmt_err_o,
  output logic [7:0] calc_o,
  output logic [9:0] recv_o
);

  chk_state_t state_reg, state_next;
  logic [7:0] sum_reg, sum_next;
  logic [7:0] commit_reg, commit_next;
  logic       field_start_reg, field_start_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [9:0] val_reg, val_next;
  logic       done_reg, done_next;
  logic       match_reg, match_next;
  logic       fmt_err_reg, fmt_err_next;
  logic [7:0] calc_reg, calc_next;
  logic [9:0] recv_reg, recv_next;

  logic       is_digit;
  logic [3:0] digit_val;
  logic       is_soh;
  logic [7:0] sum_acc;

  fix_ascii_digit u_digit (
    .data     (data_i),
    .is_digit (is_digit),
    .value    (digit_val)
  );

  assign is_soh  = (data_i == SOH);
  assign sum_acc = sum_reg + data_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      sum_reg         <= '0;
      commit_reg      <= '0;
      field_start_reg <= 1'b0;
      cnt_reg         <= '0;
      val_reg         <= '0;
      done_reg        <= 1'b0;
      match_reg       <= 1'b0;
      fmt_err_reg     <= 1'b0;
      calc_reg        <= '0;
      recv_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      sum_reg         <= sum_next;
      commit_reg      <= commit_next;
      field_start_reg <= field_start_next;
      cnt_reg         <= cnt_next;
      val_reg         <= val_next;
      done_reg        <= done_next;
      match_reg       <= match_next;
      fmt_err_reg     <= fmt_err_next;
      calc_reg        <= calc_next;
      recv_reg        <= recv_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sum_next         = sum_reg;
    commit_next      = commit_reg;
    field_start_next = field_start_reg;
    cnt_next         = cnt_reg;
    val_next         = val_reg;
    done_next        = 1'b0;
    match_next       = match_reg;
    fmt_err_next     = fmt_err_reg;
    calc_next        = calc_reg;
    recv_next        = recv_reg;

    // REPORT lasts exactly one cycle; any byte offered there (including sop) is dropped.
    if (state_reg == REPORT) begin
      state_next = IDLE;
    end else if (valid_i) begin
      field_start_next = is_soh;
      if (sop_i) begin
        sum_next    = data_i;
        commit_next = '0;
        state_next  = BODY;
      end else begin
        case (state_reg)
          IDLE: ;
          BODY, TAG1, TAG0: begin
            sum_next = sum_acc;
            if (is_soh) commit_next = sum_acc;
            state_next = BODY;
            if (state_reg == BODY && field_start_reg && data_i == ASCII_1)
              state_next = TAG1;
            if (state_reg == TAG1 && data_i == ASCII_0)
              state_next = TAG0;
            if (state_reg == TAG0 && data_i == ASCII_EQ) begin
              state_next = DIG;
              cnt_next   = '0;
              val_next   = '0;
            end
          end
          DIG: begin
            if (is_digit && cnt_reg != 2'd3) begin
              val_next = val_reg * 10'd10 + {6'd0, digit_val};
              cnt_next = cnt_reg + 2'd1;
            end else if (is_soh) begin
              state_next   = REPORT;
              done_next    = 1'b1;
              calc_next    = commit_reg;
              recv_next    = val_reg;
              fmt_err_next = (cnt_reg != 2'd3);
              match_next   = (cnt_reg == 2'd3) && (val_reg == {2'b00, commit_reg});
            end else begin
              state_next = SKIP;
            end
          end
          SKIP: begin
            if (is_soh) begin
              state_next   = REPORT;
              done_next    = 1'b1;
              calc_next    = commit_reg;
              recv_next    = val_reg;
              fmt_err_next = 1'b1;
              match_next   = 1'b0;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  assign done_o    = done_reg;
  assign match_o   = match_reg;
  assign fmt_err_o = fmt_err_reg;
  assign calc_o    = calc_reg;
  assign recv_o    = recv_reg;

endmodule

// File: tb/tb_fix_checksum_check.sv
// Directed bench for fix_checksum_check with a string-level checksum/trailer model.
module tb_fix_checksum_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       sop_i;
  logic       done_o;
  logic       match_o;
  logic       fmt_err_o;
  logic [7:0] calc_o;
  logic [9:0] recv_o;

  typedef struct {
    logic [7:0] calc;
    logic [9:0] recv;
    logic       ferr;
    logic       match;
  } verdict_t;

  verdict_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fix_checksum_check dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .sop_i     (sop_i),
    .done_o    (done_o),
    .match_o   (match_o),
    .fmt_err_o (fmt_err_o),
    .calc_o    (calc_o),
    .recv_o    (recv_o)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // '|' in a message string stands for SOH.
  function automatic void to_bytes(input string s, output byte unsigned b[$]);
    b = {};
    for (int i = 0; i < s.len(); i++)
      b.push_back((s[i] == "|") ? 8'h01 : s[i]);
  endfunction

  // Checksum = sum of every byte before the first "10=" that opens a field.
  function automatic verdict_t model(input string s);
    byte unsigned b[$];
    int sum = 0, start = -1, cnt = 0, val = 0;
    bit err = 0;
    verdict_t v;
    to_bytes(s, b);
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0 && i + 2 < b.size() && b[i-1] == 8'h01 &&
          b[i] == "1" && b[i+1] == "0" && b[i+2] == "=") begin
        start = i;
        break;
      end
      sum += b[i];
    end
    for (int j = start + 3; j < b.size() && b[j] != 8'h01; j++) begin
      if (!err && b[j] >= 8'h30 && b[j] <= 8'h39 && cnt < 3) begin
        val = val * 10 + (b[j] - 8'h30);
        cnt++;
      end else begin
        err = 1;
      end
    end
    if (cnt != 3) err = 1;
    v.calc  = sum[7:0];
    v.recv  = val[9:0];
    v.ferr  = err;
    v.match = !err && (val == (sum % 256));
    return v;
  endfunction

  task automatic send_byte(input byte unsigned b, input bit sop, input int bub_max);
    int gaps = (bub_max > 0) ? $urandom_range(0, bub_max) : 0;
    for (int k = 0; k < gaps; k++) begin
      valid_i = 1'b0;
      data_i  = 8'hA5;
      @(posedge clk); #1;
    end
    valid_i = 1'b1;
    data_i  = b;
    sop_i   = sop;
    @(posedge clk); #1;
    valid_i = 1'b0;
    sop_i   = 1'b0;
  endtask

  // Complete messages are scored and checked for done one cycle after the final SOH.
  task automatic send_msg(input string s, input bit scored, input int bub_max);
    byte unsigned b[$];
    to_bytes(s, b);
    if (scored) exp_q.push_back(model(s));
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], i == 0, bub_max);
    if (scored) begin
      check({"done_latency ", s}, int'(done_o), 1);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        verdict_t e;
        e = exp_q.pop_front();
        check("calc",    int'(calc_o),    int'(e.calc));
        check("recv",    int'(recv_o),    int'(e.recv));
        check("fmt_err", int'(fmt_err_o), int'(e.ferr));
        check("match",   int'(match_o),   int'(e.match));
      end
    end
  end

  initial begin
    verdict_t p;
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",  int'(done_o), 0);
    check("rst_match", int'(match_o), 0);
    check("rst_fmt",   int'(fmt_err_o), 0);
    check("rst_calc",  int'(calc_o), 0);
    check("rst_recv",  int'(recv_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed pins on the model itself.
    p = model("8=A|10=183|");        check("pin_calc_183", int'(p.calc), 183); check("pin_match_183", int'(p.match), 1);
    p = model("8=AAAA|10=122|");     check("pin_calc_122", int'(p.calc), 122);
    p = model("8=AAAA|10=999|");     check("pin_recv_999", int'(p.recv), 999); check("pin_match_999", int'(p.match), 0);
    p = model("8=A|108=B|10=208|");  check("pin_calc_208", int'(p.calc), 208);
    p = model("8=A|10=1x3|");        check("pin_ferr_1x3", int'(p.ferr), 1);

    send_msg("8=A|10=183|", 1, 0);
    send_msg("8=AAAA|10=122|", 1, 0);
    send_msg("8=AAAA|10=999|", 1, 0);
    send_msg("8=A|108=B|10=208|", 1, 0);
    send_msg("8=A|10=18|", 1, 0);
    send_msg("8=A|10=1x3|", 1, 0);
    send_msg("8=A|10=1834|", 1, 0);
    send_msg("8=A|10=183|", 1, 3);

    // Abort mid-trailer, then a clean message: a single done is expected.
    send_msg("8=AAA|10=1", 0, 0);
    send_msg("8=A|10=183|", 1, 0);

    // Reset while parsing digits clears everything and reports nothing.
    send_msg("8=A|10=1", 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_done",  int'(done_o), 0);
    check("midrst_match", int'(match_o), 0);
    check("midrst_fmt",   int'(fmt_err_o), 0);
    check("midrst_calc",  int'(calc_o), 0);
    check("midrst_recv",  int'(recv_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    send_msg("8=AAAA|10=122|", 1, 2);

    repeat (4) @(posedge clk);
    #1;
    check("pending_verdicts", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fix_checksum_check.md
# fix_checksum_check

Downstream consumer of the FIX byte stream: accumulates the mod-256 byte sum of an inbound FIX message and parses the `10=NNN<SOH>` trailer. It then reports whether the received checksum matches the computed one. It sits after the message framer and alongside the outbound checksum generator, and feeds accept/reject to the session layer.

## Interface
- `SOH`, default 8'h01: field delimiter byte.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `data_i`, in, 8: message byte, sampled when `valid_i`=1.
- `valid_i`, in, 1: byte strobe; cycles with `valid_i`=0 are bubbles and change no state.
- `sop_i`, in, 1: qualified by `valid_i`; marks the first byte of a message (the `8` of `8=`).
- `done_o`, out, 1: one-cycle pulse; the trailer is complete and the verdict outputs are valid.
- `match_o`, out, 1: received value equals computed value; valid with `done_o`, held until the next `done_o`.
- `fmt_err_o`, out, 1: malformed trailer; valid with `done_o`, held until the next `done_o`.
- `calc_o`, out, 8: computed checksum; held until the next `done_o`.
- `recv_o`, out, 10: parsed trailer value (0–999); held until the next `done_o`.
- Reset value of all outputs is 0.

## Operation
- Running sum `sum[7:0]` adds each accepted byte in BODY, TAG1 and TAG0, with natural 8-bit wrap.
- On every accepted SOH in BODY, `commit` is set to the sum including that SOH.
- The computed checksum is `commit` at the moment `10=` is recognised at a field start. The trailer bytes are excluded.
- A byte is at a field start if the previous accepted byte was SOH.
- States:
  - IDLE: wait for `sop_i`. The sop byte initialises `sum` to `data_i` and `commit` to 0, then → BODY.
  - BODY:
    - `1` at a field start → TAG1.
    - Otherwise accumulate; SOH updates `commit`.
  - TAG1: `0` → TAG0; any other byte → BODY. The byte is accumulated; if it is SOH, `commit` updates.
  - TAG0:
    - `=` → DIG, and clear the digit count and the 10-bit value.
    - Any other byte (e.g. `108=`) → BODY. The byte is accumulated; SOH updates `commit`.
  - DIG:
    - On each ASCII digit: `val = val*10 + d`, `cnt++`.
    - On SOH: go to REPORT with `fmt_err` = (`cnt` != 3).
    - On a non-digit non-SOH byte, or a 4th digit: set `fmt_err`, → SKIP.
  - SKIP: discard bytes until SOH → REPORT with `fmt_err`=1.
  - REPORT:
    - Drive `done_o`=1 and update `calc_o`, `recv_o` and `fmt_err_o`.
    - `match_o` = !`fmt_err` && (`recv` == {2'b0, `commit`}).
    - Then → IDLE, regardless of `valid_i`.
- `sop_i` accepted in any state other than IDLE or REPORT aborts the current message silently (no `done_o`) and restarts accumulation with that byte.
- `sop_i` in REPORT is lost; the framer guarantees at least one cycle between the trailer SOH and the next sop.
- Values above 255 (up to 999) are parsed without overflow and always mismatch.
- `rst` mid-message: return to IDLE, clear all outputs and accumulators; a partial message is never reported.

## Timing
- `done_o` is asserted exactly one cycle after the clock edge that samples the trailer-terminating SOH.
- Throughput is one byte per cycle in all states except REPORT, which lasts one cycle.
- Bubbles (`valid_i`=0) stretch latency by the bubble count and do not alter results.
- Minimum message-to-message gap is 1 cycle (the REPORT cycle).

## Structure
- Shared package `fix_pkg` holds:
  - `SOH` and ASCII constants `ASCII_0`, `ASCII_1`, `ASCII_EQ`.
  - The state enum `chk_state_t` (IDLE, BODY, TAG1, TAG0, DIG, SKIP, REPORT).
- Sub-module `fix_ascii_digit` is combinational: byte → `is_digit`, `value[3:0]`. It is shared with the outbound checksum formatter.
- The remainder (FSM, accumulators, 10-bit parser, compare) is a single module.

## Test plan
- `8=A<SOH>10=183<SOH>` (sum 56+61+65+1) → `done_o` 1 cycle after the final SOH; `match_o`=1, `calc_o`=183, `recv_o`=183, `fmt_err_o`=0.
- `8=AAAA<SOH>10=122<SOH>` (378 mod 256) → `match_o`=1, `calc_o`=122. Repeat with `10=999` → `match_o`=0, `recv_o`=999.
- False tag: `8=A<SOH>108=B<SOH>10=208<SOH>` → `match_o`=1, `calc_o`=208.
- Malformed trailers:
  - `10=18<SOH>` → `fmt_err_o`=1, `match_o`=0.
  - `10=1x3<SOH>` → `fmt_err_o`=1; `done_o` only after the SOH.
- Bubbles: random `valid_i` gaps on case 1 → identical outputs, delayed only by the gap count.
- Abort and reset:
  - `sop_i` in the middle of a message, followed by the valid message of case 1 → a single `done_o` with `match_o`=1.
  - `rst` asserted in DIG → all outputs 0, no `done_o`.
